// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear stopwatch: a prescaler gates increment events into a cascaded
// BCD digit chain, with saturation at all nines.
module bcd_stopwatch_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  running,
    output logic                  done,
    output logic                  step
);

    localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [4*DIGITS-1:0] digits_inc;
    logic                step_q, step_d;
    logic [DIGITS:0]     carry;
    logic                all_nines;
    logic                event_tick;

    // Ripple-carry decimal increment; carry out of the top digit means all nines.
    assign carry[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] cur;
            assign cur = digits_q[4*gi +: 4];
            assign digits_inc[4*gi +: 4] = !carry[gi]     ? cur   :
                                           (cur == 4'd9)  ? 4'd0  : cur + 4'd1;
            assign carry[gi+1] = carry[gi] && (cur == 4'd9);
        end
    endgenerate

    assign all_nines  = carry[DIGITS];
    assign event_tick = (presc_q == PRESC_MAX);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        digits_d = digits_q;
        step_d   = 1'b0;
        if (clear) begin
            state_d  = S_IDLE;
            presc_d  = '0;
            digits_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // start and stop together behave as start immediately followed by stop
                    if (start) state_d = stop ? S_PAUSE : S_RUN;
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_PAUSE;
                    end else if (event_tick) begin
                        presc_d = '0;
                        if (all_nines) begin
                            state_d = S_DONE;
                        end else begin
                            digits_d = digits_inc;
                            step_d   = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (start && !stop) state_d = S_RUN;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            digits_q <= '0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            digits_q <= digits_d;
            step_q   <= step_d;
        end
    end

    assign digits  = digits_q;
    assign running = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign step    = step_q;

endmodule

// File: doc/bcd_stopwatch_ctrl.md
# bcd_stopwatch_ctrl

Run/pause/clear controller for a chain of cascaded mod-10 (BCD) digit counters. A prescaler divides `clk` into increment events. An FSM gates those events, and a ripple-carry decimal chain advances the digits. The block sits between user command pulses (start/stop/clear) and the display path, and provides the sequencing that the standalone decade counter lacks.

## Interface
- `DIGITS`, default 4: number of BCD digits, ≥1.
- `PRESCALE`, default 10: number of RUN-state clk cycles per increment event, ≥1.

- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — command pulse: begin or resume counting.
- `stop`  in  1  — command pulse: pause counting.
- `clear`  in  1  — command pulse: zero digits and prescaler, return to IDLE.
- `digits`  out  4*DIGITS  — BCD value; digit k is at bits [4k+3:4k], digit 0 is least significant.
- `running`  out  1  — 1 while the state is RUN.
- `done`  out  1  — 1 while the state is DONE (saturated at all nines).
- `step`  out  1  — one-cycle pulse, asserted in the same cycle as each `digits` update.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Encoding is free.
- Reset: state=IDLE, `digits`=0, prescaler=0, `running`=0, `done`=0, `step`=0.
- Command priority when several are asserted in one cycle: `clear` > `stop` > `start`.
- IDLE:
  - `start` → RUN.
  - `stop` is ignored.
  - `clear` keeps IDLE and re-zeroes digits and prescaler.
- RUN:
  - The prescaler counts 0..PRESCALE-1.
  - When it is at PRESCALE-1, an increment event fires: prescaler → 0, the digits advance.
  - `stop` → PAUSE. Prescaler and digits hold, and no increment occurs in that cycle even if the prescaler is at PRESCALE-1.
  - `start` has no effect.
- PAUSE:
  - Prescaler and digits hold.
  - `start` → RUN, and prescaler counting resumes from the held value.
- DONE:
  - Digits hold at all nines.
  - `start` and `stop` are ignored.
  - Only `clear` (→ IDLE, zeros) or `rst` leave this state.
- `clear` from any state → IDLE with digits=0 and prescaler=0 at the next edge.
- Digit advance is decimal with ripple carry:
  - Digit 0 goes +1.
  - A digit at 9 wraps to 0 and carries into the next digit.
  - Each digit stays in 0..9 at all times; the encodings 10–15 never appear.
- Saturation: an increment event while all digits are 9 leaves the digits at all nines and moves the state to DONE. `step` is not asserted for this event.
- `step` = 1 exactly in the cycles where `digits` changed due to an increment. It is never asserted on `clear` or `rst`.

## Timing
- All outputs are registered, and no output depends combinationally on an input.
- `start` sampled at edge N (state IDLE or PAUSE):
  - `running`=1 from after edge N.
  - From IDLE, the first `digits` change and `step` pulse are visible after edge N+PRESCALE.
  - From PAUSE with held prescaler value p, they are visible after edge N+PRESCALE-p.
- Steady RUN: one increment every PRESCALE cycles. With PRESCALE=1, `digits` increments every cycle.
- `stop` sampled at edge N: `running`=0 after edge N, and `digits` is unchanged from its value before edge N.
- Saturating event at edge N: `done`=1 and `running`=0 after edge N, with `digits` still all nines.
- `clear` or `rst` at edge N: all outputs take their reset values after edge N. This holds mid-count and when coinciding with an increment event; clear/reset wins.

## Test plan
- DIGITS=2, PRESCALE=3:
  - Reset, then `start` pulse at cycle 0.
  - `digits` must read 0x01 after edge 3, 0x02 after edge 6, and 0x10 after edge 30.
  - `step` must be high exactly once every 3 cycles.
- DIGITS=2, PRESCALE=3, carry and saturation:
  - Run to 0x98, then 0x99.
  - At the next event, `digits` stays 0x99, `done`=1, `running`=0, and there is no `step`.
  - A following `start` must be ignored.
  - `clear` then gives 0x00 and IDLE.
- Pause and resume:
  - Issue `stop` when the prescaler is at 1. `digits` is frozen for 20 cycles.
  - `start` at edge N → next increment visible after edge N+2.
- Simultaneous commands:
  - `start`+`stop` in IDLE → PAUSE.
  - `stop`+`clear` in RUN → IDLE with 0x00.
  - `clear` coinciding with an increment event → 0x00 with no `step`.
- PRESCALE=1, DIGITS=1:
  - `digits` steps 0..9 on consecutive cycles after `start`.
  - On the 10th event, `done`=1 with digit 9.
- Synchronous `rst` asserted mid-RUN at digits 0x47 → all outputs are zero after that edge. No change occurs before the edge.
